// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared constants for the bit-serial adder/subtractor
package serial_add_sub_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// rtl/serial_add_sub_fa_cell.sv - combinational single-bit full adder
module fa_cell (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    // sum and majority carry of three input bits
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor with start/done handshake
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             s;
    logic             co;
    logic             accept;
    logic             last;

    fa_cell u_fa (
        .s  (s),
        .co (co),
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry)
    );

    // new sum bit enters at the MSB; after WIDTH shifts r_next is the full result
    assign r_next = WIDTH'({s, r_sh} >> 1);
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (cnt == CW'(WIDTH - 1));

    // FSM, operand/result shifting and output registers
    // On the final edge the carry register still holds the carry into the MSB
    // (the carry-in itself when WIDTH=1), so overflow is carry ^ co there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= (mode == MODE_ADD) ? B : ~B;
            carry <= (mode == MODE_SUB);
            cnt   <= '0;
            state <= S_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        Sum   <= r_next;
                        Cout  <= co;
                        Ovf   <= carry ^ co;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed self-checking bench for serial_add_sub
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, mode8, start1, mode1;
    logic [7:0] a8, b8, sum8;
    logic [0:0] a1, b1, sum1;
    logic       cout8, ovf8, busy8, done8;
    logic       cout1, ovf1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .A(a8), .B(b8),
        .Sum(sum8), .Cout(cout8), .Ovf(ovf8), .busy(busy8), .done(done8)
    );

    serial_add_sub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .A(a1), .B(b1),
        .Sum(sum1), .Cout(cout1), .Ovf(ovf1), .busy(busy1), .done(done1)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start an 8-bit op, return edges from accept to done and busy-high samples
    task automatic run8(input logic m, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt);
        mode8 = m; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy8) bcnt++;
            tick();
            lat++;
            if (done8) break;
        end
    endtask

    task automatic run1(input logic m, input logic a, input logic b, output int lat);
        mode1 = m; a1 = a; b1 = b; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (done1) break;
        end
    endtask

    typedef struct {
        logic       m;
        logic [7:0] a, b, s;
        logic       c, v;
    } vec8_t;

    vec8_t vt[5];
    int lat, bcnt, n2;
    logic saw_done;
    logic fa_s, fa_c, ci, bb;

    initial begin
        rst = 1'b1; start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
        start1 = 0; mode1 = 0; a1 = 0; b1 = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        expect_eq("rst_sum", sum8, 8'h00);
        expect_eq("rst_cout", cout8, 1'b0);
        expect_eq("rst_ovf", ovf8, 1'b0);
        expect_eq("rst_busy", busy8, 1'b0);
        expect_eq("rst_done", done8, 1'b0);
        expect_eq("rst_busy1", busy1, 1'b0);

        vt[0] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vt[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vt[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            run8(vt[k].m, vt[k].a, vt[k].b, lat, bcnt);
            expect_eq($sformatf("v%0d_latency", k), lat, 8);
            expect_eq($sformatf("v%0d_busy_cycles", k), bcnt, 8);
            expect_eq($sformatf("v%0d_sum", k), sum8, vt[k].s);
            expect_eq($sformatf("v%0d_cout", k), cout8, vt[k].c);
            expect_eq($sformatf("v%0d_ovf", k), ovf8, vt[k].v);
            tick();
            expect_eq($sformatf("v%0d_done_pulse", k), done8, 1'b0);
        end

        // start pulsed during RUN with other operands must be ignored
        mode8 = 0; a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        mode8 = 1; a8 = 8'hAA; b8 = 8'h33; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 3;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (done8) break;
        end
        expect_eq("ign_latency", lat, 8);
        expect_eq("ign_sum", sum8, 8'h10);
        tick(); tick();
        expect_eq("ign_idle", busy8, 1'b0);

        // start held through DONE: back-to-back op with new operands sampled there
        mode8 = 0; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        tick();
        mode8 = 1; a8 = 8'h30; b8 = 8'h05;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (done8) break;
        end
        expect_eq("b2b_first_latency", lat, 8);
        expect_eq("b2b_first_sum", sum8, 8'h33);
        tick();
        expect_eq("b2b_rebusy", busy8, 1'b1);
        expect_eq("b2b_done_drop", done8, 1'b0);
        start8 = 1'b0;
        n2 = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n2++;
            if (done8) break;
        end
        expect_eq("b2b_interval", n2, 9);
        expect_eq("b2b_second_sum", sum8, 8'h2B);
        expect_eq("b2b_second_cout", cout8, 1'b1);
        expect_eq("b2b_second_ovf", ovf8, 1'b0);
        tick(); tick();

        // reset at RUN cycle 4 aborts with no done
        mode8 = 0; a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_eq("abort_busy", busy8, 1'b0);
        expect_eq("abort_sum", sum8, 8'h00);
        expect_eq("abort_cout", cout8, 1'b0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8) saw_done = 1'b1;
            tick();
        end
        expect_eq("abort_no_done", saw_done, 1'b0);
        run8(1'b0, 8'h03, 8'h04, lat, bcnt);
        expect_eq("post_abort_latency", lat, 8);
        expect_eq("post_abort_sum", sum8, 8'h07);
        tick();

        // WIDTH=1: full-adder truth table; carry-in 1 via subtract of ~B
        for (int k = 0; k < 8; k++) begin
            ci = k[2]; bb = k[1];
            {fa_c, fa_s} = 2'(k[0]) + 2'(bb) + 2'(ci);
            run1(ci, k[0], ci ? ~bb : bb, lat);
            expect_eq($sformatf("w1_%0d_latency", k), lat, 1);
            expect_eq($sformatf("w1_%0d_sum", k), sum1, fa_s);
            expect_eq($sformatf("w1_%0d_cout", k), cout1, fa_c);
            expect_eq($sformatf("w1_%0d_ovf", k), ovf1, ci ^ fa_c);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
